// File: rtl/mult_sched.sv
// mult_sched: two-requester scheduler in front of one shared 32x32 multiplier.
// One operation is in flight at a time. Requester 0 (core EX) can be flushed.
// Requester 1 (accelerator) is served round-robin against requester 0.
module mult_sched #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  input  logic        flush0,
  output logic [31:0] mul_op_a,
  output logic [31:0] mul_op_b,
  output logic        mul_signed_a,
  output logic        mul_signed_b,
  input  logic [63:0] mul_product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operand signedness {a, b}: MUL and MULH are signed/signed, MULHSU is
  // signed/unsigned, MULHU is unsigned/unsigned.
  function automatic logic [1:0] op_signs(input logic [1:0] op);
    logic [1:0] s;
    case (op)
      2'b00:   s = 2'b11;
      2'b01:   s = 2'b11;
      2'b10:   s = 2'b10;
      2'b11:   s = 2'b00;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

  // MUL returns the low word of the product, every MULH* form the high word.
  function automatic logic [31:0] pick_result(input logic [1:0] op, input logic [63:0] prod);
    logic [31:0] r;
    case (op)
      2'b00:   r = prod[31:0];
      default: r = prod[63:32];
    endcase
    return r;
  endfunction

  state_t      state_r;
  state_t      state_nxt;
  logic [2:0]  cnt_r;
  logic        rr_r;       // port granted most recently; the other wins a tie
  logic        owner_r;    // port that owns the operation in flight
  logic [1:0]  op_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic        signed_a_r;
  logic        signed_b_r;
  logic [31:0] result_r;

  logic        gnt0;
  logic        gnt1;
  logic        cand0;
  logic        issue;
  logic        flush_own;
  logic        rsp_hs;
  logic [1:0]  sel_op;
  logic [1:0]  sel_signs;

  // Arbitration: grant only in IDLE, flush0 masks requester 0, ties go to the
  // port that was not granted last.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    cand0 = req0_valid & ~flush0;
    if (rst_n && (state_r == IDLE)) begin
      if (cand0 && req1_valid) begin
        if (rr_r) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (cand0) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign issue      = gnt0 | gnt1;
  assign sel_op     = gnt1 ? req1_op : req0_op;
  assign sel_signs  = op_signs(sel_op);
  assign flush_own  = flush0 & ~owner_r & (state_r != IDLE);
  assign rsp_hs     = (state_r == RESP) & (owner_r ? rsp1_ready : rsp0_ready);

  // Next-state logic; a flush of the owner's operation outranks everything.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (issue) begin
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (flush_own) begin
          state_nxt = IDLE;
        end else if (cnt_r == 3'd0) begin
          state_nxt = RESP;
        end else begin
          state_nxt = BUSY;
        end
      end
      RESP: begin
        if (flush_own || rsp_hs) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Operation capture at issue, latency countdown and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 3'd0;
      rr_r       <= 1'b1;
      owner_r    <= 1'b0;
      op_r       <= 2'b00;
      op_a_r     <= 32'd0;
      op_b_r     <= 32'd0;
      signed_a_r <= 1'b0;
      signed_b_r <= 1'b0;
      result_r   <= 32'd0;
    end else begin
      if (issue) begin
        owner_r    <= gnt1;
        rr_r       <= gnt1;
        op_r       <= sel_op;
        op_a_r     <= gnt1 ? req1_a : req0_a;
        op_b_r     <= gnt1 ? req1_b : req0_b;
        signed_a_r <= sel_signs[1];
        signed_b_r <= sel_signs[0];
        cnt_r      <= 3'(LATENCY - 1);
      end else if ((state_r == BUSY) && !flush_own) begin
        if (cnt_r == 3'd0) begin
          result_r <= pick_result(op_r, mul_product);
        end else begin
          cnt_r <= cnt_r - 3'd1;
        end
      end else if ((state_r != IDLE) && (state_nxt == IDLE)) begin
        result_r <= 32'd0;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign mul_op_a     = op_a_r;
  assign mul_op_b     = op_b_r;
  assign mul_signed_a = signed_a_r;
  assign mul_signed_b = signed_b_r;
  assign busy         = (state_r != IDLE);
  assign rsp0_valid   = (state_r == RESP) & ~owner_r;
  assign rsp1_valid   = (state_r == RESP) & owner_r;
  assign rsp0_result  = rsp0_valid ? result_r : 32'd0;
  assign rsp1_result  = rsp1_valid ? result_r : 32'd0;

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from operand launch to product valid at mul_product; legal range 1..7.
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester 0 (core EX) / requester 1 (accelerator) has an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  grant; handshake when valid&ready.
REQ-006 SHALL have ports req0_op/req1_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have ports req0_a/req0_b/req1_a/req1_b  input  32  operands.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid  output  1, rsp0_ready/rsp1_ready  input  1, rsp0_result/rsp1_result  output  32.
REQ-009 SHALL have port flush0  input  1  kill requester 0's pending/in-flight operation.
REQ-010 SHALL have ports mul_op_a/mul_op_b  output  32, mul_signed_a/mul_signed_b  output  1  to shared multiplier.
REQ-011 SHALL have port mul_product  input  64  multiplier result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, BUSY, RESP; exactly one operation in flight.
REQ-014 IDLE: ready asserted combinationally only to the granted port, only in IDLE; no ready in BUSY/RESP.
REQ-015 Arbitration: one valid -> that port; both valid -> port not granted last (round-robin pointer updated on each issue).
REQ-016 flush0 high in IDLE SHALL suppress req0_ready that cycle (req1 may still be granted).
REQ-017 On issue (cycle T): latch operands, op, owner; mul_op_a/b, mul_signed_a/b registered, valid from T+1, held stable until state leaves BUSY.
REQ-018 Signedness: MUL 1/1, MULH 1/1, MULHSU 1/0, MULHU 0/0 (a/b).
REQ-019 BUSY: 3-bit down-counter loaded LATENCY-1 at issue; product sampled at end of the BUSY cycle with counter 0 (cycle T+LATENCY); transition to RESP.
REQ-020 Result: MUL -> mul_product[31:0]; others -> mul_product[63:32]; stored in a register.
REQ-021 RESP: owner's rsp_valid high from T+LATENCY+1, result stable until rsp handshake; other port's rsp_valid low.
REQ-022 rsp handshake -> IDLE next cycle; earliest next issue one cycle after response handshake (min issue interval LATENCY+2).
REQ-023 flush0 with owner=0 in BUSY or RESP SHALL return to IDLE next cycle, no rsp0_valid thereafter, product discarded; flush0 with owner=1 ignored.
REQ-024 flush0 and rsp0_ready same cycle in RESP: flush wins, counted as discarded (no further effect).
REQ-025 rsp_result SHALL be 0 whenever corresponding rsp_valid low.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, counter 0, RR pointer = port 1 (port 0 wins first contention), all ready/rsp_valid/busy 0, mul_op_a/b 0, mul_signed_* 0, results 0.
REQ-027 Reset mid-operation SHALL abandon the operation with no response after release.
REQ-028 First issue possible in the first clk edge after rst_n deasserts.

Verification
REQ-029 LATENCY=1, req0 MUL a=0x0000_0007 b=0x0000_0006 at T -> mul_op valid T+1, rsp0_valid at T+2 with 0x0000_002A, busy T+1..T+2.
REQ-030 req1 MULH a=0xFFFF_FFFF b=0xFFFF_FFFF -> signed 1/1, result 0x0000_0000; MULHU same operands -> 0xFFFF_FFFE; MULHSU a=0xFFFF_FFFF b=0x0000_0002 -> 0xFFFF_FFFF.
REQ-031 Both valid continuously from reset, 4 ops -> grant order 0,1,0,1; each grant only in IDLE.
REQ-032 LATENCY=3, req0 issued, flush0 pulsed at T+2 -> IDLE at T+3, no rsp0_valid; pending req1 granted at T+3.
REQ-033 rsp1_ready held low 5 cycles in RESP -> rsp1_valid and rsp1_result stable, no new ready to either port.
REQ-034 rst_n asserted during BUSY -> all outputs 0 immediately; after release no stale response.
